// File: rtl/alu_decode_stage_if.sv
// Decode-stage bundle: IF/ID inputs, pipeline control and the registered ID/EX outputs.
// The master side is the decode stage, which produces the E-stage controls.
interface alu_decode_stage_if #(parameter int CNT_W = 8);
  logic [31:0]      InstrD;
  logic [4:0]       RdD;
  logic             ValidD;
  logic             StallE;
  logic             FlushE;
  logic             ValidE;
  logic             RegWriteE;
  logic [1:0]       ResultSrcE;
  logic             MemWriteE;
  logic             BranchE;
  logic             JumpE;
  logic             ALUSrcE;
  logic [1:0]       ImmSrcE;
  logic [2:0]       ALUControlE;
  logic [4:0]       RdE;
  logic             IllegalE;
  logic [CNT_W-1:0] IllegalCount;

  // Handshake: ValidD qualifies InstrD/RdD every cycle; StallE holds and FlushE
  // clears the ID/EX register, with FlushE taking priority. ValidE qualifies all E outputs.
  modport master (
    input  InstrD, RdD, ValidD, StallE, FlushE,
    output ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
           ALUSrcE, ImmSrcE, ALUControlE, RdE, IllegalE, IllegalCount
  );

  modport slave (
    output InstrD, RdD, ValidD, StallE, FlushE,
    input  ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
           ALUSrcE, ImmSrcE, ALUControlE, RdE, IllegalE, IllegalCount
  );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode for the ALU subset (lw/sw/R/I-ALU/beq/jal) registered into ID/EX,
// with stall/flush handling and a saturating illegal-instruction counter.
module alu_decode_stage #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_decode_stage_if.master   bus
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic [4:0] rd;
    logic       illegal;
  } ctrl_t;

  ctrl_t            dec;
  ctrl_t            ctrl_d, ctrl_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [2:0] alu_funct;
  logic       funct_bad;
  logic       illegal;
  logic       capture;

  assign opcode = bus.InstrD[6:0];
  assign funct3 = bus.InstrD[14:12];
  assign funct7 = bus.InstrD[31:25];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.InstrD[24:15], bus.InstrD[11:7]};

  // funct7[5] only selects sub for register-register ops; addi's immediate bit is ignored
  always_comb begin
    alu_funct = ALU_ADD;
    funct_bad = 1'b0;
    case (funct3)
      3'b000:  alu_funct = (opcode[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_funct = ALU_SLT;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: funct_bad = 1'b1;
    endcase
  end

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rd    = bus.RdD;
    illegal   = 1'b0;
    case (opcode)
      OP_LW: begin
        illegal        = (funct3 != 3'b010);
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src    = 1'b1;
        dec.imm_src    = 2'b00;
        dec.alu_control = ALU_ADD;
      end
      OP_SW: begin
        illegal        = (funct3 != 3'b010);
        dec.mem_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm_src    = 2'b01;
        dec.alu_control = ALU_ADD;
      end
      OP_R: begin
        illegal = funct_bad
                  || ((funct7 != 7'b0000000) && (funct7 != 7'b0100000))
                  || ((funct7 == 7'b0100000) && (funct3 != 3'b000));
        dec.reg_write   = 1'b1;
        dec.alu_control = alu_funct;
      end
      OP_I: begin
        illegal         = funct_bad;
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = alu_funct;
      end
      OP_BEQ: begin
        illegal         = (funct3 != 3'b000);
        dec.branch      = 1'b1;
        dec.imm_src     = 2'b10;
        dec.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        dec.reg_write   = 1'b1;
        dec.result_src  = 2'b10;
        dec.jump        = 1'b1;
        dec.imm_src     = 2'b11;
        dec.alu_control = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal instructions travel down the pipe as valid but inert, keeping only rd
    if (illegal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
      dec.rd      = bus.RdD;
    end
  end

  assign capture = !bus.FlushE && !bus.StallE;

  always_comb begin
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    if (bus.FlushE) begin
      ctrl_d = '0;
    end else if (!bus.StallE) begin
      ctrl_d = bus.ValidD ? dec : '0;
    end
    if (capture && bus.ValidD && illegal && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.ValidE       = ctrl_q.valid;
  assign bus.RegWriteE    = ctrl_q.reg_write;
  assign bus.ResultSrcE   = ctrl_q.result_src;
  assign bus.MemWriteE    = ctrl_q.mem_write;
  assign bus.BranchE      = ctrl_q.branch;
  assign bus.JumpE        = ctrl_q.jump;
  assign bus.ALUSrcE      = ctrl_q.alu_src;
  assign bus.ImmSrcE      = ctrl_q.imm_src;
  assign bus.ALUControlE  = ctrl_q.alu_control;
  assign bus.RdE          = ctrl_q.rd;
  assign bus.IllegalE     = ctrl_q.illegal;
  assign bus.IllegalCount = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed decode/stall/flush/reset steps, then random
// instructions checked against a mnemonic-level reference model. Two DUTs share stimulus.
module tb_alu_decode_stage;

  localparam int W = 19;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic [4:0] rd;
    logic       illegal;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q[$];
  exp_t         model_ctrl;
  int           model_cnt8;
  int           model_cnt2;

  alu_decode_stage_if #(.CNT_W(8)) bus8 ();
  alu_decode_stage_if #(.CNT_W(2)) bus2 ();

  alu_decode_stage #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  alu_decode_stage #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: name the instruction, then look its controls up by name
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t  r;
    string mn;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    mn = "bad";
    case (op)
      7'h03: if (f3 == 3'd2) mn = "lw";
      7'h23: if (f3 == 3'd2) mn = "sw";
      7'h63: if (f3 == 3'd0) mn = "beq";
      7'h6f: mn = "jal";
      7'h33: begin
        if (f7 == 7'h00) begin
          if (f3 == 3'd0) mn = "add";
          else if (f3 == 3'd2) mn = "slt";
          else if (f3 == 3'd6) mn = "or";
          else if (f3 == 3'd7) mn = "and";
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          mn = "sub";
        end
      end
      7'h13: begin
        if (f3 == 3'd0) mn = "add";
        else if (f3 == 3'd2) mn = "slt";
        else if (f3 == 3'd6) mn = "or";
        else if (f3 == 3'd7) mn = "and";
        if (mn != "bad") mn = {mn, "i"};
      end
      default: mn = "bad";
    endcase
    r = '0;
    r.valid = 1'b1;
    r.rd = i[11:7];
    case (mn)
      "lw":   begin r.reg_write = 1; r.result_src = 2'b01; r.alu_src = 1; end
      "sw":   begin r.mem_write = 1; r.alu_src = 1; r.imm_src = 2'b01; end
      "beq":  begin r.branch = 1; r.imm_src = 2'b10; r.alu_control = 3'b001; end
      "jal":  begin r.reg_write = 1; r.result_src = 2'b10; r.jump = 1; r.imm_src = 2'b11; end
      "add":  begin r.reg_write = 1; end
      "sub":  begin r.reg_write = 1; r.alu_control = 3'b001; end
      "slt":  begin r.reg_write = 1; r.alu_control = 3'b101; end
      "or":   begin r.reg_write = 1; r.alu_control = 3'b011; end
      "and":  begin r.reg_write = 1; r.alu_control = 3'b010; end
      "addi": begin r.reg_write = 1; r.alu_src = 1; end
      "slti": begin r.reg_write = 1; r.alu_src = 1; r.alu_control = 3'b101; end
      "ori":  begin r.reg_write = 1; r.alu_src = 1; r.alu_control = 3'b011; end
      "andi": begin r.reg_write = 1; r.alu_src = 1; r.alu_control = 3'b010; end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.valid       = bus8.ValidE;
    o.reg_write   = bus8.RegWriteE;
    o.result_src  = bus8.ResultSrcE;
    o.mem_write   = bus8.MemWriteE;
    o.branch      = bus8.BranchE;
    o.jump        = bus8.JumpE;
    o.alu_src     = bus8.ALUSrcE;
    o.imm_src     = bus8.ImmSrcE;
    o.alu_control = bus8.ALUControlE;
    o.rd          = bus8.RdE;
    o.illegal     = bus8.IllegalE;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare full control word from the queue, plus both counters
  task automatic compare(input string tag);
    logic [W-1:0] e;
    exp_t o;
    o = observed();
    e = exp_q.pop_front();
    checks++;
    assert (W'(o) === e) else begin
      errors++;
      $error("FAIL %s ctrl observed=%0h expected=%0h", tag, W'(o), e);
    end
    chk({tag, "_cnt8"}, 32'(bus8.IllegalCount), 32'(model_cnt8));
    chk({tag, "_cnt2"}, 32'(bus2.IllegalCount), 32'(model_cnt2));
  endtask

  task automatic model_reset();
    model_ctrl = '0;
    model_cnt8 = 0;
    model_cnt2 = 0;
  endtask

  // driver: apply one cycle of inputs, advance, update model, compare
  task automatic step(input string tag, input logic [31:0] instr,
                      input logic v, input logic s, input logic f);
    exp_t d;
    bus8.InstrD = instr; bus8.RdD = instr[11:7]; bus8.ValidD = v;
    bus8.StallE = s;     bus8.FlushE = f;
    bus2.InstrD = instr; bus2.RdD = instr[11:7]; bus2.ValidD = v;
    bus2.StallE = s;     bus2.FlushE = f;
    @(posedge clk);
    #1;
    d = ref_decode(instr);
    if (f) begin
      model_ctrl = '0;
    end else if (!s) begin
      model_ctrl = v ? d : '0;
      if (v && d.illegal) begin
        if (model_cnt8 < 255) model_cnt8++;
        if (model_cnt2 < 3) model_cnt2++;
      end
    end
    exp_q.push_back(W'(model_ctrl));
    compare(tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk({tag, "_ctrl"}, 32'(W'(observed())), 32'd0);
    chk({tag, "_cnt8"}, 32'(bus8.IllegalCount), 32'd0);
    chk({tag, "_cnt2"}, 32'(bus2.IllegalCount), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0] ops[7];
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
    ops[4] = 7'h63; ops[5] = 7'h6f; ops[6] = 7'($urandom);
    i = $urandom;
    i[6:0] = ops[$urandom_range(0, 6)];
    case ($urandom_range(0, 3))
      0: i[31:25] = 7'h00;
      1: i[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) i[14:12] = 3'($urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0,1) ? 2 : 6));
    return i;
  endfunction

  int sat_exp[5];

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b0;
    bus8.InstrD = '0; bus8.RdD = '0; bus8.ValidD = 0; bus8.StallE = 0; bus8.FlushE = 0;
    bus2.InstrD = '0; bus2.RdD = '0; bus2.ValidD = 0; bus2.StallE = 0; bus2.FlushE = 0;
    #1;
    chk("reset_ctrl", 32'(W'(observed())), 32'd0);
    chk("reset_cnt", 32'(bus8.IllegalCount), 32'd0);
    #10;
    rst = 1'b1;
    @(negedge clk);

    // reset mid-stream
    step("add_pre", 32'h002081B3, 1, 0, 0);
    async_reset("midreset");

    // decode matrix
    step("add", 32'h002081B3, 1, 0, 0);
    chk("add_aluc", 32'(bus8.ALUControlE), 32'h0);
    chk("add_rw", 32'(bus8.RegWriteE), 32'h1);
    chk("add_rd", 32'(bus8.RdE), 32'd3);
    step("sub", 32'h402081B3, 1, 0, 0);
    chk("sub_aluc", 32'(bus8.ALUControlE), 32'h1);
    step("slt", 32'h0020A1B3, 1, 0, 0);
    chk("slt_aluc", 32'(bus8.ALUControlE), 32'h5);
    step("lw", 32'h0040A283, 1, 0, 0);
    chk("lw_rsrc", 32'(bus8.ResultSrcE), 32'h1);
    chk("lw_rd", 32'(bus8.RdE), 32'd5);
    step("beq", 32'h00208463, 1, 0, 0);
    chk("beq_br", 32'(bus8.BranchE), 32'h1);
    chk("beq_imm", 32'(bus8.ImmSrcE), 32'h2);
    step("addi_f7", 32'h40008093, 1, 0, 0);
    chk("addi_aluc", 32'(bus8.ALUControlE), 32'h0);

    // illegal
    step("xor", 32'h0020C1B3, 1, 0, 0);
    chk("xor_ill", 32'(bus8.IllegalE), 32'h1);
    chk("xor_valid", 32'(bus8.ValidE), 32'h1);
    chk("xor_cnt", 32'(bus8.IllegalCount), 32'd1);
    step("zero", 32'h00000000, 1, 0, 0);
    chk("zero_cnt", 32'(bus8.IllegalCount), 32'd2);

    // stall / flush priority
    step("st_add", 32'h002081B3, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step("stall", 32'h402081B3, 1, 1, 0);
      chk("stall_aluc", 32'(bus8.ALUControlE), 32'h0);
    end
    step("st_fl", 32'h402081B3, 1, 1, 1);
    chk("stfl_valid", 32'(bus8.ValidE), 32'h0);

    // bubble
    step("bubble", 32'h002081B3, 0, 0, 0);
    chk("bubble_valid", 32'(bus8.ValidE), 32'h0);
    chk("bubble_cnt", 32'(bus8.IllegalCount), 32'd2);

    // stalled illegal then flushed: counted once
    step("ill_cap", 32'h0020C1B3, 1, 0, 0);
    step("ill_hold", 32'h0020C1B3, 1, 1, 0);
    step("ill_flush", 32'h0020C1B3, 1, 1, 1);
    chk("ill_once", 32'(bus8.IllegalCount), 32'd3);

    // saturation of the 2-bit counter
    async_reset("satreset");
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;
    for (int k = 0; k < 5; k++) begin
      step("sat", 32'hFFFFFFFF, 1, 0, 0);
      chk("sat_cnt2", 32'(bus2.IllegalCount), 32'(sat_exp[k]));
    end

    // randomized
    for (int k = 0; k < 400; k++) begin
      step("rand", rand_instr(), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Produces control for the RV32I execute-stage ALU and datapath: decodes opcode/funct3/funct7[5] into ALUControl and datapath controls.
- Registers them into the ID/EX pipeline register with valid, stall and flush handling.
- Sits between the instruction register (IF/ID) and the execute stage. It is the producing end of the 3-bit ALUControl interface.
- Counts illegal/unsupported instructions.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- InstrD  input  32  instruction in decode stage
- RdD  input  5  destination register (passed through; equals InstrD[11:7])
- ValidD  input  1  InstrD holds a real instruction
- StallE  input  1  hold ID/EX register contents
- FlushE  input  1  insert bubble into ID/EX register
- ValidE  output  1  registered: EX holds a real instruction
- RegWriteE  output  1  registered register-file write enable
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4
- MemWriteE  output  1  store enable
- BranchE  output  1  beq
- JumpE  output  1  jal
- ALUSrcE  output  1  1 = immediate operand B
- ImmSrcE  output  2  00 I, 01 S, 10 B, 11 J
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RdE  output  5  registered destination
- IllegalE  output  1  registered: instruction was illegal/unsupported
- IllegalCount  output  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, including IllegalCount.
- Latency: 1 cycle, with combinational decode of InstrD into registered E outputs.
- Per-cycle register update priority:
  - FlushE=1: every output except IllegalCount is set to 0 (bubble). FlushE beats StallE.
  - Else StallE=1: all registers hold.
  - Else: capture the decode.
- ValidD=0 with neither flush nor stall: captures a bubble, same as flush.
- Main decode by opcode (fields listed as RegWrite, ResultSrc, MemWrite, Branch, Jump, ALUSrc, ImmSrc, ALUOp):
  - 0000011 lw (funct3 must be 010): 1, 01, 0, 0, 0, 1, 00, add.
  - 0100011 sw (funct3 must be 010): 0, 00, 1, 0, 0, 1, 01, add.
  - 0110011 R-type: 1, 00, 0, 0, 0, 0, 00, funct decode.
  - 0010011 I-ALU: 1, 00, 0, 0, 0, 1, 00, funct decode.
  - 1100011 beq (funct3 must be 000): 0, 00, 0, 1, 0, 0, 10, sub.
  - 1101111 jal: 1, 10, 0, 0, 1, 0, 11, add.
- Funct decode:
  - funct3 000: sub only if opcode[5]=1 and funct7[5]=1, else add. addi never subtracts.
  - funct3 010: slt (101).
  - funct3 110: or (011).
  - funct3 111: and (010).
- Illegal cases:
  - Any other opcode.
  - Funct3 mismatch on lw/sw/beq.
  - Other funct3 values (sll, sltu, xor, srl/sra), which the ALU does not support.
  - R-type with funct7 not 0000000/0100000.
  - R-type with funct7=0100000 and funct3≠000.
- On an illegal instruction: ValidE=1, IllegalE=1, and all write/branch/jump enables, ALUSrc, ImmSrc, ResultSrc and ALUControl are 0. RdE is still captured.
- IllegalCount:
  - Increments by 1 on each capture (not flush, not stall) with ValidD=1 and an illegal decode.
  - Saturates at 2^CNT_W−1.
  - Unaffected by flush; cleared only by reset.
- Stall then flush in consecutive cycles: the held instruction is dropped and is not recounted.

Test Plan:
- Reset mid-stream: drive add, assert rst=0 asynchronously between clock edges -> all outputs 0 immediately, IllegalCount=0.
- Decode matrix, ValidD=1, no stall/flush, check the next cycle:
  - 0x002081B3 (add) -> ALUControlE=000, RegWriteE=1, ALUSrcE=0, RdE=3.
  - 0x402081B3 -> ALUControlE=001.
  - 0x0020A1B3 -> 101.
  - 0x0040A283 (lw x5) -> ResultSrcE=01, ALUSrcE=1, ALUControlE=000, RdE=5.
  - 0x00208463 (beq) -> BranchE=1, ImmSrcE=10, ALUControlE=001.
- Illegal: 0x0020C1B3 (xor) -> ValidE=1, IllegalE=1, RegWriteE=0, IllegalCount 0→1. Then 0x00000000 -> IllegalCount=2.
- Stall/flush priority:
  - Capture add, then StallE=1 for 3 cycles with sub on InstrD -> ALUControlE stays 000.
  - StallE=1 and FlushE=1 together -> ValidE=0, all controls 0.
- Bubble: ValidD=0 with InstrD=0x002081B3 -> ValidE=0, RegWriteE=0, IllegalCount unchanged.
- Saturation with CNT_W=2: 5 consecutive illegal captures -> IllegalCount reads 1, 2, 3, 3, 3.
